mouse_position_tracker: RTL and testbench

- Downstream consumer of the mouse transceiver's decoded 3-byte PS/2 packet (status, dX, dY) plus the master state machine's one-cycle packet-complete interrupt.
- Converts relative motion into absolute clamped X/Y coordinates for a 160x120 VGA-style grid, and registers button state and left/right click edges.
- Feeds the display and bus-peripheral logic.

---
 rtl/mouse_position_tracker.sv | 153 +++++++++++++++
 tb/tb_mouse_position_tracker.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mouse_position_tracker.sv
// rtl/mouse_position_tracker.sv - PS/2 packet to absolute clamped X/Y position, buttons and click pulses
// Optional MOUSE_TRACKER_WRAP_EN: positions wrap around the grid instead of saturating.
module mouse_position_tracker #(
   parameter int MOUSE_LIMIT_X = 160,
   parameter int MOUSE_LIMIT_Y = 120
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       PKT_VALID,
   input  logic [7:0] STATUS_BYTE,
   input  logic [7:0] DX_BYTE,
   input  logic [7:0] DY_BYTE,
   output logic [7:0] MOUSE_X,
   output logic [7:0] MOUSE_Y,
   output logic [2:0] MOUSE_BUTTONS,
   output logic       LEFT_CLICK,
   output logic       RIGHT_CLICK,
   output logic       POS_UPDATED,
   output logic       SYNC_ERR
);

   localparam logic signed [9:0] LIM_X   = 10'(MOUSE_LIMIT_X);
   localparam logic signed [9:0] LIM_Y   = 10'(MOUSE_LIMIT_Y);
   localparam logic [7:0]        RESET_X = 8'(MOUSE_LIMIT_X / 2);
   localparam logic [7:0]        RESET_Y = 8'(MOUSE_LIMIT_Y / 2);

   typedef enum logic [2:0] {IDLE, CHECK, CALC_X, CALC_Y, COMMIT} trackerState;

   trackerState state, nextState;

   logic [7:0] capStatus, capDx, capDy;
   logic [7:0] pendStatus, pendDx, pendDy;
   logic       pendValid;
   logic [7:0] nextX, nextY;
   logic       leaving;

   logic signed [9:0] dxExt, dyExt, sumX, sumY;

   function automatic logic [7:0] fitRange(input logic signed [9:0] sum,
                                           input logic signed [9:0] limit);
      logic signed [9:0] v;
      v = sum;
`ifdef MOUSE_TRACKER_WRAP_EN
      // |d| up to 255 against a limit near 120 can need several corrections
      for (int i = 0; i < 3; i++) begin
         if (v < 0)
            v = v + limit;
         else if (v >= limit)
            v = v - limit;
      end
`else
      if (v < 0)
         v = '0;
      else if (v > limit - 10'sd1)
         v = limit - 10'sd1;
`endif
      return v[7:0];
   endfunction

   assign dxExt = capStatus[6] ? '0 : {capStatus[4], capStatus[4], capDx};
   assign dyExt = capStatus[7] ? '0 : {capStatus[5], capStatus[5], capDy};
   assign sumX  = $signed({2'b00, MOUSE_X}) + dxExt;
   assign sumY  = $signed({2'b00, MOUSE_Y}) - dyExt;

   assign leaving = (state == COMMIT) || (state == CHECK && !capStatus[3]);

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (PKT_VALID) nextState = CHECK;
         CHECK:   if (capStatus[3]) nextState = CALC_X;
                  else nextState = (pendValid || PKT_VALID) ? CHECK : IDLE;
         CALC_X:  nextState = CALC_Y;
         CALC_Y:  nextState = COMMIT;
         COMMIT:  nextState = (pendValid || PKT_VALID) ? CHECK : IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state         <= IDLE;
         capStatus     <= '0;
         capDx         <= '0;
         capDy         <= '0;
         pendStatus    <= '0;
         pendDx        <= '0;
         pendDy        <= '0;
         pendValid     <= 1'b0;
         nextX         <= RESET_X;
         nextY         <= RESET_Y;
         MOUSE_X       <= RESET_X;
         MOUSE_Y       <= RESET_Y;
         MOUSE_BUTTONS <= '0;
         LEFT_CLICK    <= 1'b0;
         RIGHT_CLICK   <= 1'b0;
         POS_UPDATED   <= 1'b0;
         SYNC_ERR      <= 1'b0;
      end else begin
         state       <= nextState;
         LEFT_CLICK  <= 1'b0;
         RIGHT_CLICK <= 1'b0;
         POS_UPDATED <= 1'b0;
         SYNC_ERR    <= 1'b0;

         // A packet arriving as the FSM leaves is queued behind any pending one
         if (state == IDLE) begin
            if (PKT_VALID) begin
               capStatus <= STATUS_BYTE;
               capDx     <= DX_BYTE;
               capDy     <= DY_BYTE;
            end
         end else if (leaving) begin
            if (pendValid) begin
               capStatus <= pendStatus;
               capDx     <= pendDx;
               capDy     <= pendDy;
               pendValid <= PKT_VALID;
               if (PKT_VALID) begin
                  pendStatus <= STATUS_BYTE;
                  pendDx     <= DX_BYTE;
                  pendDy     <= DY_BYTE;
               end
            end else if (PKT_VALID) begin
               capStatus <= STATUS_BYTE;
               capDx     <= DX_BYTE;
               capDy     <= DY_BYTE;
            end
         end else if (PKT_VALID) begin
            pendStatus <= STATUS_BYTE;
            pendDx     <= DX_BYTE;
            pendDy     <= DY_BYTE;
            pendValid  <= 1'b1;
         end

         case (state)
            CHECK:   if (!capStatus[3]) SYNC_ERR <= 1'b1;
            CALC_X:  nextX <= fitRange(sumX, LIM_X);
            CALC_Y:  nextY <= fitRange(sumY, LIM_Y);
            COMMIT: begin
               MOUSE_X       <= nextX;
               MOUSE_Y       <= nextY;
               MOUSE_BUTTONS <= capStatus[2:0];
               LEFT_CLICK    <= capStatus[0] & ~MOUSE_BUTTONS[0];
               RIGHT_CLICK   <= capStatus[1] & ~MOUSE_BUTTONS[1];
               POS_UPDATED   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mouse_position_tracker.sv
// tb/tb_mouse_position_tracker.sv - scoreboard bench for mouse_position_tracker
module tb_mouse_position_tracker;

   localparam int LIMX = 160;
   localparam int LIMY = 120;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       PKT_VALID = 1'b0;
   logic [7:0] STATUS_BYTE = '0;
   logic [7:0] DX_BYTE = '0;
   logic [7:0] DY_BYTE = '0;
   logic [7:0] MOUSE_X, MOUSE_Y;
   logic [2:0] MOUSE_BUTTONS;
   logic       LEFT_CLICK, RIGHT_CLICK, POS_UPDATED, SYNC_ERR;

   mouse_position_tracker #(.MOUSE_LIMIT_X(LIMX), .MOUSE_LIMIT_Y(LIMY)) dut (
      .CLK(CLK), .RESET(RESET), .PKT_VALID(PKT_VALID),
      .STATUS_BYTE(STATUS_BYTE), .DX_BYTE(DX_BYTE), .DY_BYTE(DY_BYTE),
      .MOUSE_X(MOUSE_X), .MOUSE_Y(MOUSE_Y), .MOUSE_BUTTONS(MOUSE_BUTTONS),
      .LEFT_CLICK(LEFT_CLICK), .RIGHT_CLICK(RIGHT_CLICK),
      .POS_UPDATED(POS_UPDATED), .SYNC_ERR(SYNC_ERR)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      bit syncErr;
      int x, y, buttons, lclk, rclk;
   } expT;

   expT expQ[$];
   int  checks = 0;
   int  errors = 0;
   int  mx, my, mb;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int fit(input int v, input int lim);
`ifdef MOUSE_TRACKER_WRAP_EN
      return ((v % lim) + lim) % lim;
`else
      if (v < 0) return 0;
      if (v > lim - 1) return lim - 1;
      return v;
`endif
   endfunction

   function automatic int delta(input bit ovf, input bit sgn, input logic [7:0] b);
      if (ovf) return 0;
      return sgn ? int'(b) - 256 : int'(b);
   endfunction

   task automatic modelReset();
      mx = LIMX / 2;
      my = LIMY / 2;
      mb = 0;
   endtask

   task automatic modelApply(input logic [7:0] st, input logic [7:0] dxb, input logic [7:0] dyb);
      expT e;
      e.syncErr = !st[3];
      e.lclk = 0;
      e.rclk = 0;
      if (st[3]) begin
         mx = fit(mx + delta(st[6], st[4], dxb), LIMX);
         my = fit(my - delta(st[7], st[5], dyb), LIMY);
         e.lclk = (st[0] && !mb[0]) ? 1 : 0;
         e.rclk = (st[1] && !mb[1]) ? 1 : 0;
         mb = int'(st[2:0]);
      end
      e.x = mx;
      e.y = my;
      e.buttons = mb;
      expQ.push_back(e);
   endtask

   task automatic drive(input logic [7:0] st, input logic [7:0] dxb, input logic [7:0] dyb);
      PKT_VALID = 1'b1;
      STATUS_BYTE = st;
      DX_BYTE = dxb;
      DY_BYTE = dyb;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic sendPkt(input logic [7:0] st, input logic [7:0] dxb, input logic [7:0] dyb);
      drive(st, dxb, dyb);
      modelApply(st, dxb, dyb);
      idle(1);
      PKT_VALID = 1'b0;
      idle(6);
   endtask

   always @(negedge CLK) begin
      if (!RESET) begin
         if (POS_UPDATED || SYNC_ERR) begin
            if (expQ.size() == 0) begin
               chk("unexpected_output_pulse", int'(POS_UPDATED) + int'(SYNC_ERR), 0);
            end else begin
               expT e;
               e = expQ.pop_front();
               chk("sync_err", int'(SYNC_ERR), int'(e.syncErr));
               chk("pos_updated", int'(POS_UPDATED), int'(!e.syncErr));
               chk("mouse_x", int'(MOUSE_X), e.x);
               chk("mouse_y", int'(MOUSE_Y), e.y);
               chk("buttons", int'(MOUSE_BUTTONS), e.buttons);
               chk("left_click", int'(LEFT_CLICK), e.lclk);
               chk("right_click", int'(RIGHT_CLICK), e.rclk);
            end
         end else begin
            chk("stray_click", int'(LEFT_CLICK) + int'(RIGHT_CLICK), 0);
         end
      end
   end

   initial begin
      logic [7:0] st;
      modelReset();
      idle(2);
      chk("reset_x", int'(MOUSE_X), 80);
      chk("reset_y", int'(MOUSE_Y), 60);
      chk("reset_buttons", int'(MOUSE_BUTTONS), 0);
      chk("reset_pulses", int'({LEFT_CLICK, RIGHT_CLICK, POS_UPDATED, SYNC_ERR}), 0);
      RESET = 1'b0;
      idle(2);

      sendPkt(8'h08, 8'h0A, 8'h05);
      chk("basic_x", int'(MOUSE_X), 90);
      chk("basic_y", int'(MOUSE_Y), 55);

      sendPkt(8'h18, 8'h00, 8'h00);
`ifdef MOUSE_TRACKER_WRAP_EN
      chk("neg_wrap_x", int'(MOUSE_X), 154);
`else
      chk("neg_clamp_x", int'(MOUSE_X), 0);
`endif
      for (int i = 0; i < 3; i++) sendPkt(8'h08, 8'hFF, 8'h00);
`ifndef MOUSE_TRACKER_WRAP_EN
      chk("pos_clamp_x", int'(MOUSE_X), 159);
`endif

      sendPkt(8'h48, 8'h7F, 8'h03);
      chk("ovf_y", int'(MOUSE_Y), 52);

      sendPkt(8'h08, 8'h00, 8'h00);
      sendPkt(8'h09, 8'h00, 8'h00);
      chk("left_buttons", int'(MOUSE_BUTTONS), 1);
      sendPkt(8'h09, 8'h00, 8'h00);
      sendPkt(8'h00, 8'h11, 8'h22);

      // Reset while the FSM sits in CALC_X: no commit may follow
      drive(8'h08, 8'h05, 8'h05);
      idle(1);
      PKT_VALID = 1'b0;
      @(posedge CLK);
      #2;
      RESET = 1'b1;
      #1;
      chk("midreset_x", int'(MOUSE_X), 80);
      chk("midreset_y", int'(MOUSE_Y), 60);
      chk("midreset_buttons", int'(MOUSE_BUTTONS), 0);
      modelReset();
      idle(1);
      RESET = 1'b0;
      idle(8);

      // Three back-to-back packets: the middle one is overwritten in the pending slot
      drive(8'h08, 8'h01, 8'h00);
      modelApply(8'h08, 8'h01, 8'h00);
      idle(1);
      drive(8'h08, 8'h02, 8'h00);
      idle(1);
      drive(8'h08, 8'h03, 8'h00);
      modelApply(8'h08, 8'h03, 8'h00);
      idle(1);
      PKT_VALID = 1'b0;
      idle(12);
      chk("burst_x", int'(MOUSE_X), 84);
      chk("burst_drained", expQ.size(), 0);

      for (int i = 0; i < 150; i++) begin
         st = 8'($urandom) & 8'hF7;
         if ($urandom_range(0, 7) != 0) st = st | 8'h08;
         if ($urandom_range(0, 3) != 0) st = st & 8'h3F;
         sendPkt(st, 8'($urandom), 8'($urandom));
      end

      idle(10);
      chk("queue_drained", expQ.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
